vliw_hazard_ctrl: RTL and testbench

- Central pipeline controller for the dual-slot (ALU + MEM) 5-stage VLIW core.
- Watches register indices and control bits in the ID, EX, MEM and WB stages, plus the data-memory ready line and branch resolution.
- Drives the pipeline-register write enables, the IF/ID/EX flush lines, the ID/EX bubble (p2_pipeline_stall) and the EX-stage operand forwarding selects.
- Holds a small freeze/redirect FSM, a memory-wait watchdog and stall/flush performance counters.

---
 rtl/vliw_ctrl_pkg.sv | 18 +
 rtl/vliw_fwd_sel.sv | 36 +++
 rtl/vliw_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_vliw_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_ctrl_pkg.sv
// Shared definitions for the dual-slot VLIW pipeline controller.
// Provides the register index width, the controller state enum and the
// EX-stage operand forwarding select encodings.
package vliw_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF        = 2'b00;  // register file value
  localparam logic [1:0] FWD_EXMEM_ALU = 2'b01;  // ALU result in EX/MEM
  localparam logic [1:0] FWD_WB_ALU    = 2'b10;  // ALU result in WB
  localparam logic [1:0] FWD_WB_MEM    = 2'b11;  // load data in WB

endpackage

// File: rtl/vliw_fwd_sel.sv
// Forwarding select for one EX-stage source operand.
// Ports:
//   src                               EX-stage source register index
//   p3_alu_rd / p3_alu_regWrite       EX/MEM ALU destination and write enable
//   p4_mem_rd / p4_mem_regWrite       WB load destination and write enable
//   p4_alu_rd / p4_alu_regWrite       WB ALU destination and write enable
//   sel                               2-bit operand select (vliw_ctrl_pkg FWD_*)
// The youngest producer wins; inside WB the MEM slot beats the ALU slot, which
// defines the result of an (illegal) same-bundle duplicate destination.
module vliw_fwd_sel
  import vliw_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] p3_alu_rd,
  input  logic             p3_alu_regWrite,
  input  logic [REG_W-1:0] p4_mem_rd,
  input  logic             p4_mem_regWrite,
  input  logic [REG_W-1:0] p4_alu_rd,
  input  logic             p4_alu_regWrite,
  output logic [1:0]       sel
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (p3_alu_regWrite && (p3_alu_rd == src)) begin
      sel = FWD_EXMEM_ALU;
    end else if (p4_mem_regWrite && (p4_mem_rd == src)) begin
      sel = FWD_WB_MEM;
    end else if (p4_alu_regWrite && (p4_alu_rd == src)) begin
      sel = FWD_WB_ALU;
    end
  end

endmodule

// File: rtl/vliw_hazard_ctrl.sv
// Central pipeline controller for the dual-slot (ALU + MEM) 5-stage VLIW core.
// Ports:
//   clk, reset (async, active-low)
//   id_*            ID-stage source indices and read qualifiers
//   p2_*            EX-stage sources, destinations and control bits
//   p3_*            MEM-stage ALU destination and control bits
//   p4_*            WB-stage destinations and write enables
//   branch_taken    EX-stage branch/jump resolved taken
//   mem_ready       data memory finished the current MEM-stage access
//   pipe_en, pc_write, ifid_write              pipeline write enables
//   IF_flush, ID_flush, EX_flush, p2_pipeline_stall  flush/bubble controls
//   fwd_alu_rn, fwd_alu_rm, fwd_mem_rn, fwd_mem_rd   EX operand selects
//   mem_timeout     sticky memory-wait watchdog error
//   stall_cnt, flush_cnt, memwait_cnt          saturating perf counters
// Hazard decisions are combinational so the pipeline reacts in the same cycle
// the condition is visible. The state register only remembers that a freeze
// is in progress, so the wait persists even if MEM-stage bits wobble.
module vliw_hazard_ctrl
  import vliw_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_alu_rn,
  input  logic [REG_W-1:0] id_alu_rm,
  input  logic [REG_W-1:0] id_mem_rn,
  input  logic [REG_W-1:0] id_mem_rd,
  input  logic             id_alu_uses_rm,
  input  logic             id_mem_is_store,
  input  logic [REG_W-1:0] p2_alu_rn,
  input  logic [REG_W-1:0] p2_alu_rm,
  input  logic [REG_W-1:0] p2_mem_rn,
  input  logic [REG_W-1:0] p2_mem_rd,
  input  logic [REG_W-1:0] p2_alu_rd,
  input  logic             p2_alu_regWrite,
  input  logic             p2_mem_regWrite,
  input  logic             p2_memRead,
  input  logic [REG_W-1:0] p3_alu_rd,
  input  logic             p3_alu_regWrite,
  input  logic             p3_memRead,
  input  logic             p3_memWrite,
  input  logic [REG_W-1:0] p4_alu_rd,
  input  logic [REG_W-1:0] p4_mem_rd,
  input  logic             p4_alu_regWrite,
  input  logic             p4_mem_regWrite,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             IF_flush,
  output logic             ID_flush,
  output logic             p2_pipeline_stall,
  output logic             EX_flush,
  output logic [1:0]       fwd_alu_rn,
  output logic [1:0]       fwd_alu_rm,
  output logic [1:0]       fwd_mem_rn,
  output logic [1:0]       fwd_mem_rd,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  ctrl_state_e     state;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_busy;
  logic            freeze;
  logic            redirect;
  logic            id_match;
  logic            load_use;
  logic [1:0]      sel_alu_rn, sel_alu_rm, sel_mem_rn, sel_mem_rd;

  // The EX ALU destination never causes a stall: its result forwards from
  // EX/MEM one cycle later, so these inputs are intentionally unused.
  logic unused_ex_alu_dst;
  assign unused_ex_alu_dst = ^{p2_alu_rd, p2_alu_regWrite};

  // The exit cycle (mem_ready back high) already behaves as RUN.
  assign mem_busy = (state == MEM_WAIT) || p3_memRead || p3_memWrite;
  assign freeze   = mem_busy && !mem_ready;
  assign redirect = !freeze && branch_taken;

  assign id_match = (p2_mem_rd == id_alu_rn) ||
                    (p2_mem_rd == id_mem_rn) ||
                    (id_alu_uses_rm  && (p2_mem_rd == id_alu_rm)) ||
                    (id_mem_is_store && (p2_mem_rd == id_mem_rd));

  // A redirect masks load-use: the dependent instruction is flushed anyway.
  assign load_use = !freeze && !branch_taken && p2_memRead && p2_mem_regWrite && id_match;

  vliw_fwd_sel u_fwd_alu_rn (
    .src(p2_alu_rn), .p3_alu_rd(p3_alu_rd), .p3_alu_regWrite(p3_alu_regWrite),
    .p4_mem_rd(p4_mem_rd), .p4_mem_regWrite(p4_mem_regWrite),
    .p4_alu_rd(p4_alu_rd), .p4_alu_regWrite(p4_alu_regWrite), .sel(sel_alu_rn)
  );
  vliw_fwd_sel u_fwd_alu_rm (
    .src(p2_alu_rm), .p3_alu_rd(p3_alu_rd), .p3_alu_regWrite(p3_alu_regWrite),
    .p4_mem_rd(p4_mem_rd), .p4_mem_regWrite(p4_mem_regWrite),
    .p4_alu_rd(p4_alu_rd), .p4_alu_regWrite(p4_alu_regWrite), .sel(sel_alu_rm)
  );
  vliw_fwd_sel u_fwd_mem_rn (
    .src(p2_mem_rn), .p3_alu_rd(p3_alu_rd), .p3_alu_regWrite(p3_alu_regWrite),
    .p4_mem_rd(p4_mem_rd), .p4_mem_regWrite(p4_mem_regWrite),
    .p4_alu_rd(p4_alu_rd), .p4_alu_regWrite(p4_alu_regWrite), .sel(sel_mem_rn)
  );
  vliw_fwd_sel u_fwd_mem_rd (
    .src(p2_mem_rd), .p3_alu_rd(p3_alu_rd), .p3_alu_regWrite(p3_alu_regWrite),
    .p4_mem_rd(p4_mem_rd), .p4_mem_regWrite(p4_mem_regWrite),
    .p4_alu_rd(p4_alu_rd), .p4_alu_regWrite(p4_alu_regWrite), .sel(sel_mem_rd)
  );

  // NOTE: outputs are gated by reset itself, not just by the state register,
  // so asserting reset mid-freeze releases the pipeline immediately.
  always_comb begin
    pipe_en           = 1'b1;
    pc_write          = 1'b1;
    ifid_write        = 1'b1;
    IF_flush          = 1'b0;
    ID_flush          = 1'b0;
    EX_flush          = 1'b0;
    p2_pipeline_stall = 1'b0;
    fwd_alu_rn        = FWD_RF;
    fwd_alu_rm        = FWD_RF;
    fwd_mem_rn        = FWD_RF;
    fwd_mem_rd        = FWD_RF;
    if (reset) begin
      fwd_alu_rn = sel_alu_rn;
      fwd_alu_rm = sel_alu_rm;
      fwd_mem_rn = sel_mem_rn;
      fwd_mem_rd = sel_mem_rd;
      if (freeze) begin
        // Lossless freeze: nothing flushes, a pending branch waits in EX.
        pipe_en    = 1'b0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (redirect) begin
        IF_flush = 1'b1;
        ID_flush = 1'b1;
      end else if (load_use) begin
        pc_write          = 1'b0;
        ifid_write        = 1'b0;
        p2_pipeline_stall = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      state <= freeze ? MEM_WAIT : RUN;

      // Watchdog: the 64th consecutive freeze cycle sets the sticky error.
      if (freeze) begin
        if (wd_cnt == WD_LAST) begin
          mem_timeout <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end else begin
        wd_cnt <= '0;
      end

      if (load_use && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (freeze && (memwait_cnt != '1)) begin
        memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vliw_hazard_ctrl.sv
// Self-checking bench for vliw_hazard_ctrl: directed cases with literal
// expectations followed by randomized stimulus against a behavioural model.
module tb_vliw_hazard_ctrl;

  localparam int CW   = 4;
  localparam int TO   = 64;
  localparam int CMAX = (1 << CW) - 1;

  localparam int K_RESET    = 0;
  localparam int K_FREEZE   = 1;
  localparam int K_REDIRECT = 2;
  localparam int K_LOADUSE  = 3;
  localparam int K_NORMAL   = 4;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd;
  logic id_alu_uses_rm, id_mem_is_store;
  logic [2:0] p2_alu_rn, p2_alu_rm, p2_mem_rn, p2_mem_rd, p2_alu_rd;
  logic p2_alu_regWrite, p2_mem_regWrite, p2_memRead;
  logic [2:0] p3_alu_rd;
  logic p3_alu_regWrite, p3_memRead, p3_memWrite;
  logic [2:0] p4_alu_rd, p4_mem_rd;
  logic p4_alu_regWrite, p4_mem_regWrite;
  logic branch_taken, mem_ready;
  logic pipe_en, pc_write, ifid_write, IF_flush, ID_flush, p2_pipeline_stall, EX_flush;
  logic [1:0] fwd_alu_rn, fwd_alu_rm, fwd_mem_rn, fwd_mem_rd;
  logic mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state
  bit m_waiting;
  int m_run;
  bit m_timeout;
  int m_stall, m_flush, m_memwait;

  vliw_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_alu_rn(id_alu_rn), .id_alu_rm(id_alu_rm), .id_mem_rn(id_mem_rn), .id_mem_rd(id_mem_rd),
    .id_alu_uses_rm(id_alu_uses_rm), .id_mem_is_store(id_mem_is_store),
    .p2_alu_rn(p2_alu_rn), .p2_alu_rm(p2_alu_rm), .p2_mem_rn(p2_mem_rn), .p2_mem_rd(p2_mem_rd),
    .p2_alu_rd(p2_alu_rd), .p2_alu_regWrite(p2_alu_regWrite), .p2_mem_regWrite(p2_mem_regWrite),
    .p2_memRead(p2_memRead), .p3_alu_rd(p3_alu_rd), .p3_alu_regWrite(p3_alu_regWrite),
    .p3_memRead(p3_memRead), .p3_memWrite(p3_memWrite), .p4_alu_rd(p4_alu_rd),
    .p4_mem_rd(p4_mem_rd), .p4_alu_regWrite(p4_alu_regWrite), .p4_mem_regWrite(p4_mem_regWrite),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pipe_en(pipe_en), .pc_write(pc_write), .ifid_write(ifid_write),
    .IF_flush(IF_flush), .ID_flush(ID_flush), .p2_pipeline_stall(p2_pipeline_stall),
    .EX_flush(EX_flush), .fwd_alu_rn(fwd_alu_rn), .fwd_alu_rm(fwd_alu_rm),
    .fwd_mem_rn(fwd_mem_rn), .fwd_mem_rd(fwd_mem_rd), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Which rule governs the current cycle, from the controller's priority list.
  function automatic int cycle_kind();
    bit reads_hit;
    if (!reset) return K_RESET;
    if ((m_waiting || p3_memRead || p3_memWrite) && !mem_ready) return K_FREEZE;
    if (branch_taken) return K_REDIRECT;
    reads_hit = (p2_mem_rd == id_alu_rn) || (p2_mem_rd == id_mem_rn) ||
                (id_alu_uses_rm && p2_mem_rd == id_alu_rm) ||
                (id_mem_is_store && p2_mem_rd == id_mem_rd);
    if (p2_memRead && p2_mem_regWrite && reads_hit) return K_LOADUSE;
    return K_NORMAL;
  endfunction

  // Nearest producer of register s, youngest first, WB MEM over WB ALU.
  function automatic logic [1:0] exp_fwd(input logic [2:0] s);
    if (!reset) return 2'b00;
    if (p3_alu_regWrite && p3_alu_rd == s) return 2'b01;
    if (p4_mem_regWrite && p4_mem_rd == s) return 2'b11;
    if (p4_alu_regWrite && p4_alu_rd == s) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_waiting = 1'b0; m_run = 0; m_timeout = 1'b0;
      m_stall = 0; m_flush = 0; m_memwait = 0;
    end else begin
      int k;
      k = cycle_kind();
      if (k == K_LOADUSE)  m_stall   = (m_stall   < CMAX) ? m_stall + 1   : CMAX;
      if (k == K_REDIRECT) m_flush   = (m_flush   < CMAX) ? m_flush + 1   : CMAX;
      if (k == K_FREEZE)   m_memwait = (m_memwait < CMAX) ? m_memwait + 1 : CMAX;
      m_run = (k == K_FREEZE) ? m_run + 1 : 0;
      if (m_run >= TO) m_timeout = 1'b1;
      m_waiting = (k == K_FREEZE);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int k;
      logic [6:0] e_ctl;  // pipe_en pc_write ifid_write IF ID stall EX
      k = cycle_kind();
      case (k)
        K_FREEZE:   e_ctl = 7'b000_00_0_0;
        K_REDIRECT: e_ctl = 7'b111_11_0_0;
        K_LOADUSE:  e_ctl = 7'b100_00_1_0;
        default:    e_ctl = 7'b111_00_0_0;
      endcase
      check("ctl", {pipe_en, pc_write, ifid_write, IF_flush, ID_flush, p2_pipeline_stall, EX_flush},
            e_ctl);
      check("fwd", {fwd_alu_rn, fwd_alu_rm, fwd_mem_rn, fwd_mem_rd},
            {exp_fwd(p2_alu_rn), exp_fwd(p2_alu_rm), exp_fwd(p2_mem_rn), exp_fwd(p2_mem_rd)});
      check("cnt", {mem_timeout, stall_cnt, flush_cnt, memwait_cnt},
            {m_timeout, CW'(m_stall), CW'(m_flush), CW'(m_memwait)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd} = '0;
    {id_alu_uses_rm, id_mem_is_store} = '0;
    {p2_alu_rn, p2_alu_rm, p2_mem_rn, p2_mem_rd, p2_alu_rd} = '0;
    {p2_alu_regWrite, p2_mem_regWrite, p2_memRead} = '0;
    p3_alu_rd = '0;
    {p3_alu_regWrite, p3_memRead, p3_memWrite} = '0;
    {p4_alu_rd, p4_mem_rd} = '0;
    {p4_alu_regWrite, p4_mem_regWrite} = '0;
    branch_taken = 1'b0;
    mem_ready    = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic set_load_use_r3();
    p2_memRead = 1'b1; p2_mem_regWrite = 1'b1; p2_mem_rd = 3'd3;
    id_alu_rn = 3'd3; id_mem_rn = 3'd5;
  endtask

  task automatic randomize_inputs();
    id_alu_rn = 3'($urandom_range(0, 7)); id_alu_rm = 3'($urandom_range(0, 7));
    id_mem_rn = 3'($urandom_range(0, 7)); id_mem_rd = 3'($urandom_range(0, 7));
    id_alu_uses_rm = 1'($urandom); id_mem_is_store = 1'($urandom);
    p2_alu_rn = 3'($urandom_range(0, 7)); p2_alu_rm = 3'($urandom_range(0, 7));
    p2_mem_rn = 3'($urandom_range(0, 7)); p2_mem_rd = 3'($urandom_range(0, 7));
    p2_alu_rd = 3'($urandom_range(0, 7));
    p2_alu_regWrite = 1'($urandom); p2_mem_regWrite = 1'($urandom);
    p2_memRead = ($urandom_range(0, 2) == 0);
    p3_alu_rd = 3'($urandom_range(0, 7)); p3_alu_regWrite = 1'($urandom);
    p3_memRead = ($urandom_range(0, 3) == 0); p3_memWrite = ($urandom_range(0, 5) == 0);
    p4_alu_rd = 3'($urandom_range(0, 7)); p4_mem_rd = 3'($urandom_range(0, 7));
    p4_alu_regWrite = 1'($urandom); p4_mem_regWrite = 1'($urandom);
    branch_taken = ($urandom_range(0, 5) == 0);
    mem_ready = ($urandom_range(0, 4) != 0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #2;
    check("reset_ctl", {pipe_en, pc_write, ifid_write, IF_flush, ID_flush, p2_pipeline_stall, EX_flush},
          7'b111_00_0_0);
    check("reset_cnt", {mem_timeout, stall_cnt, flush_cnt, memwait_cnt}, '0);
    cmp_en = 1'b1;

    // Load-use on r3: one stall cycle, then normal.
    do_reset();
    set_load_use_r3();
    #1;
    check("lu_ctl", {pipe_en, pc_write, ifid_write, p2_pipeline_stall}, 4'b1001);
    cyc();
    clear_inputs();
    #1;
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_after", {pc_write, ifid_write, p2_pipeline_stall}, 3'b110);

    // Branch over the same hazard: redirect wins.
    do_reset();
    set_load_use_r3();
    branch_taken = 1'b1;
    #1;
    check("br_ctl", {IF_flush, ID_flush, p2_pipeline_stall, pc_write, EX_flush}, 5'b11010);
    cyc();
    clear_inputs();
    #1;
    check("br_cnts", {flush_cnt, stall_cnt}, {4'd1, 4'd0});

    // Memory wait with a pending branch for 5 cycles.
    do_reset();
    p3_memRead = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) cyc();
      #1;
      check("mw_frozen", {pipe_en, IF_flush, ID_flush}, 3'b000);
    end
    cyc();
    mem_ready = 1'b1;
    #1;
    check("mw_exit", {pipe_en, IF_flush, ID_flush, memwait_cnt}, {3'b111, 4'd5});
    cyc();
    clear_inputs();
    #1;
    check("mw_flush_cnt", flush_cnt, 1);

    // Forwarding priority.
    do_reset();
    p3_alu_rd = 3'd2; p3_alu_regWrite = 1'b1;
    p4_mem_rd = 3'd2; p4_mem_regWrite = 1'b1;
    p2_alu_rn = 3'd2; p2_alu_rm = 3'd1; p2_mem_rd = 3'd1;
    #1;
    check("fwd_exmem", fwd_alu_rn, 2'b01);
    p3_alu_regWrite = 1'b0;
    #1;
    check("fwd_wbmem", fwd_alu_rn, 2'b11);
    p4_alu_rd = 3'd4; p4_alu_regWrite = 1'b1; p2_mem_rn = 3'd4;
    #1;
    check("fwd_wbalu", fwd_mem_rn, 2'b10);

    // Watchdog: 64 consecutive wait cycles.
    do_reset();
    p3_memRead = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) cyc();
    #1;
    check("wd_before", mem_timeout, 1'b0);
    cyc();
    #1;
    check("wd_set", mem_timeout, 1'b1);
    mem_ready = 1'b1;
    cyc();
    p3_memRead = 1'b0;
    #1;
    check("wd_sticky", {mem_timeout, pipe_en}, 2'b11);
    p3_memRead = 1'b1; mem_ready = 1'b0;
    cyc(); cyc();
    #1;
    check("wd_frozen", pipe_en, 1'b0);
    reset = 1'b0;
    #1;
    check("wd_async_rst", {pipe_en, mem_timeout, memwait_cnt}, {2'b10, 4'd0});
    cyc();

    // Saturation: 20 load-use cycles on a 4-bit counter.
    do_reset();
    set_load_use_r3();
    for (int i = 0; i < 20; i++) cyc();
    clear_inputs();
    #1;
    check("sat_stall", stall_cnt, 15);

    // Randomized run with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 99) != 0);
      cyc();
    end
    reset = 1'b1;
    clear_inputs();
    cyc();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
